// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display controller:
// register map, CTRL bit positions, glyph constants and the segment table.
package seg_pkg;

  localparam logic [3:0] SEG_VALUE_OFS  = 4'h0;
  localparam logic [3:0] SEG_CTRL_OFS   = 4'h4;
  localparam logic [3:0] SEG_STATUS_OFS = 4'h8;

  localparam int CTRL_DEC_BIT   = 0;
  localparam int CTRL_BLINK_BIT = 1;
  localparam int CTRL_MASK_LSB  = 8;

  localparam logic [31:0] SEG_CTRL_RESET = 32'h0000_FF00;
  localparam logic [31:0] SEG_DEC_LIMIT  = 32'd100_000_000;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_LOAD,
    BCD_SHIFT
  } bcd_state_t;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} for a hex nibble
  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter (shift-add-3).
// One LOAD cycle followed by 32 SHIFT cycles; a new start restarts it.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd
);

  bcd_state_t  state, state_next;
  logic [31:0] bin_q;
  logic [31:0] shift_q;
  logic [39:0] bcd_q;
  logic [4:0]  cnt_q;

  function automatic logic [39:0] add3_all(input logic [39:0] d);
    logic [39:0] r;
    r = d;
    for (int i = 0; i < 10; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BCD_IDLE;
    else        state <= state_next;
  end

  // Next state: a start always restarts from LOAD, an abort drops to IDLE
  always_comb begin
    state_next = state;
    case (state)
      BCD_IDLE:  if (start) state_next = BCD_LOAD;
      BCD_LOAD:  state_next = BCD_SHIFT;
      BCD_SHIFT: if (cnt_q == 5'd31) state_next = BCD_IDLE;
      default:   state_next = BCD_IDLE;
    endcase
    if (start)      state_next = BCD_LOAD;
    else if (abort) state_next = BCD_IDLE;
  end

  // Datapath: capture operand on start, clear in LOAD, adjust-and-shift in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) bin_q <= bin;
      if (!start && !abort) begin
        case (state)
          BCD_LOAD: begin
            shift_q <= bin_q;
            bcd_q   <= '0;
            cnt_q   <= '0;
          end
          BCD_SHIFT: begin
            {bcd_q, shift_q} <= {add3_all(bcd_q), shift_q} << 1;
            cnt_q            <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != BCD_IDLE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// MMIO eight-digit seven-segment display controller with hex/decimal modes.
// Optional blink support is compiled in with SEG_DISPLAY_BLINK_EN.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int SCAN_RATE_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wea,
  input  logic [3:0]  addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  tube_en,
  output logic [7:0]  tube_seg
);

  localparam int DIGIT_PERIOD = CLK_FREQ_HZ / SCAN_RATE_HZ;
  localparam int DIV_W        = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_PERIOD - 1);

  logic [31:0] value_q;
  logic        ctrl_dec_q;
  logic [7:0]  ctrl_mask_q;
  logic        ovf_q;
  logic        conv_ovf_q;
  logic [31:0] shadow_q;
  logic        shadow_dash_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]  idx_q;

  logic        wr_value, wr_ctrl, new_dec;
  logic        conv_start, conv_abort, hex_load;
  logic [31:0] conv_bin;
  logic        conv_busy, conv_done;
  logic [39:0] conv_bcd;
  logic [7:0]  en_next, seg_next;
  logic        blink_hide;

  assign wr_value   = wea && (addr == SEG_VALUE_OFS);
  assign wr_ctrl    = wea && (addr == SEG_CTRL_OFS);
  assign new_dec    = write_data[CTRL_DEC_BIT];
  assign conv_bin   = wr_value ? write_data : value_q;
  assign conv_start = (wr_value && ctrl_dec_q) || (wr_ctrl && new_dec);
  assign conv_abort = wr_ctrl && !new_dec;
  assign hex_load   = (wr_value && !ctrl_dec_q) || (wr_ctrl && !new_dec);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .abort (conv_abort),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

`ifdef SEG_DISPLAY_BLINK_EN
  localparam int BLINK_PERIOD = (CLK_FREQ_HZ / 4 > 1) ? CLK_FREQ_HZ / 4 : 1;
  localparam int BLINK_W      = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

  logic               ctrl_blink_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;
  logic               unused_bits;

  assign unused_bits = ^{write_data[31:16], write_data[7:2], conv_bcd[39:32]};

  // Blink timebase: phase flips every quarter second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_PERIOD - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Blink enable bit of CTRL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ctrl_blink_q <= SEG_CTRL_RESET[CTRL_BLINK_BIT];
    else if (wr_ctrl) ctrl_blink_q <= write_data[CTRL_BLINK_BIT];
  end

  assign blink_hide = ctrl_blink_q && blink_phase_q;
`else
  logic unused_bits;

  assign unused_bits = ^{write_data[31:16], write_data[7:1], conv_bcd[39:32]};
  assign blink_hide  = 1'b0;
`endif

  // VALUE and CTRL registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q     <= '0;
      ctrl_dec_q  <= SEG_CTRL_RESET[CTRL_DEC_BIT];
      ctrl_mask_q <= SEG_CTRL_RESET[CTRL_MASK_LSB +: 8];
    end else begin
      if (wr_value) value_q <= write_data;
      if (wr_ctrl) begin
        ctrl_dec_q  <= new_dec;
        ctrl_mask_q <= write_data[CTRL_MASK_LSB +: 8];
      end
    end
  end

  // Shadow digits: hex loads at once, decimal only when a conversion completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      shadow_dash_q <= 1'b0;
      ovf_q         <= 1'b0;
      conv_ovf_q    <= 1'b0;
    end else begin
      if (conv_start) conv_ovf_q <= (conv_bin >= SEG_DEC_LIMIT);
      if (hex_load) begin
        shadow_q      <= conv_bin;
        shadow_dash_q <= 1'b0;
        ovf_q         <= 1'b0;
      end else if (conv_done && ctrl_dec_q && !conv_start) begin
        shadow_q      <= conv_bcd[31:0];
        shadow_dash_q <= conv_ovf_q;
        ovf_q         <= conv_ovf_q;
      end
    end
  end

  // Register read mux
  always_comb begin
    read_data = '0;
    case (addr)
      SEG_VALUE_OFS: read_data = value_q;
      SEG_CTRL_OFS: begin
        read_data[CTRL_MASK_LSB +: 8] = ctrl_mask_q;
        read_data[CTRL_DEC_BIT]       = ctrl_dec_q;
`ifdef SEG_DISPLAY_BLINK_EN
        read_data[CTRL_BLINK_BIT]     = ctrl_blink_q;
`endif
      end
      SEG_STATUS_OFS: read_data[1:0] = {ovf_q, conv_busy};
      default: read_data = '0;
    endcase
  end

  // Scan divider and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Pin values for the digit currently selected
  always_comb begin
    en_next  = ~((8'b1 << idx_q) & ctrl_mask_q);
    seg_next = SEG_BLANK;
    if (ctrl_mask_q[idx_q]) begin
      seg_next = shadow_dash_q ? SEG_DASH : seg_code(shadow_q[{idx_q, 2'b00} +: 4]);
    end
    if (blink_hide) en_next = 8'hFF;
  end

  // Registered tube pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tube_en  <= 8'hFF;
      tube_seg <= 8'hFF;
    end else begin
      tube_en  <= en_next;
      tube_seg <= seg_next;
    end
  end

endmodule
